sr_multicycle_control: RTL and testbench
========================================

SR_MULTICYCLE_CONTROL -- requirements
Module: sr_multicycle_control

Interface
REQ-001 SHALL have parameter CNT_W, default 32, giving the width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port runEn, input, 1: when 1, the controller may start a new fetch.
REQ-005 SHALL have port imemReq, output, 1: instruction-memory request.
REQ-006 SHALL have port imemAck, input, 1: instruction-memory data valid for the current request.
REQ-007 SHALL have ports cmdOp, cmdF3 and cmdF7, inputs, widths 7/3/7: fields of the instruction register.
REQ-008 SHALL have port aluZero, input, 1: ALU zero flag.
REQ-009 SHALL have ports irWe and pcWe, outputs, 1 each: instruction-register and PC write enables.
REQ-010 SHALL have ports pcSrc (2), regWrite (1), aluSrc (1), wdSrc (2) and aluControl (3), all outputs, with the same encodings as the single-cycle decoder.
REQ-011 SHALL have ports trap (1), state (3) and instret (CNT_W), all outputs: sticky illegal-instruction flag, current FSM state, and count of retired instructions.

Function
REQ-012 SHALL implement the FSM states FETCH=0, DECODE=1, EXEC=2, WB=3 and TRAP=4; the state output SHALL equal the current state.
REQ-013 In FETCH, imemReq SHALL equal runEn; when imemReq and imemAck are both 1, irWe SHALL be 1 for that cycle and the next state SHALL be DECODE; otherwise the FSM SHALL stay in FETCH.
REQ-014 imemAck SHALL be ignored whenever imemReq is 0.
REQ-015 In DECODE, the controller SHALL decode {cmdF7, cmdF3, cmdOp} into an internal control register holding regWrite, aluSrc, wdSrc, aluControl, branch, jump and condZero.
REQ-016 The decode table SHALL cover:
- ADD, OR, SRL, SLTU, SUB: regWrite.
- ADDI: regWrite, aluSrc, ALU_ADD.
- LUI: regWrite, wdSrc=01.
- BEQ: branch, condZero, ALU_SUB.
- BNE: branch, ALU_SUB.
- JAL: regWrite, jump, wdSrc=10.
REQ-017 If the decode in DECODE matches none of the REQ-016 instructions, the next state SHALL be TRAP; otherwise the next state SHALL be EXEC.
REQ-018 In EXEC, aluSrc and aluControl SHALL be driven from the control register, and aluZero SHALL be captured into zeroR at the end of the cycle; the next state SHALL be WB.
REQ-019 In WB, the following SHALL hold:
- pcWe=1.
- regWrite comes from the control register.
- wdSrc comes from the control register.
- aluSrc and aluControl are held from the control register.
- pcSrc = {jump, branch & (zeroR == condZero)}.
REQ-020 In WB, instret SHALL increment by 1 with wrap-around modulo 2^CNT_W, and the next state SHALL be FETCH.
REQ-021 Latency: if the acknowledge arrives in cycle N, the FSM SHALL be in DECODE at N+1, EXEC at N+2 and WB at N+3, and imemReq may reassert at N+4 (minimum 4 cycles per instruction).
REQ-022 Outside the states named above, irWe, pcWe, regWrite, aluSrc and imemReq SHALL be 0, pcSrc and wdSrc SHALL be 00, and aluControl SHALL be ALU_ADD.
REQ-023 TRAP SHALL be terminal until reset; in TRAP, trap=1, all enables SHALL be 0 and instret SHALL hold.
REQ-024 runEn falling outside FETCH SHALL NOT abort the current instruction, which SHALL complete through WB.

Reset
REQ-025 While rst_n=0, the controller SHALL asynchronously force the following, independent of clk:
- state=FETCH.
- control register cleared.
- zeroR=0.
- instret=0.
- trap=0.
- all outputs at their REQ-022 values.
REQ-026 Reset asserted mid-instruction SHALL discard that instruction, with no pcWe or regWrite pulse.
REQ-027 After rst_n rises, the first imemReq SHALL be asserted in the first cycle in which runEn=1.

Verification
REQ-028 Bench SHALL cover: runEn=1, ack on cycle 2, ADDI opcode 0010011/F3 000 -> irWe at cycle 2; WB at cycle 5 with regWrite=1, aluSrc=1, pcWe=1, pcSrc=00; instret=1.
REQ-029 Bench SHALL cover: BEQ with aluZero=1 in EXEC -> pcSrc=01 in WB; BNE with aluZero=1 -> pcSrc=00; BNE with aluZero=0 -> pcSrc=01; regWrite=0 in all cases.
REQ-030 Bench SHALL cover: JAL (opcode 1101111) -> WB with pcSrc=10, wdSrc=10, regWrite=1.
REQ-031 Bench SHALL cover: opcode 0000000 -> TRAP at DECODE+1, trap=1, imemReq stays 0 for 20 cycles with runEn=1, and instret is unchanged.
REQ-032 Bench SHALL cover: ack withheld for 7 cycles -> FSM stays in FETCH with imemReq=1; ack presented with runEn=0 -> no irWe.
REQ-033 Bench SHALL cover: rst_n pulsed low mid-EXEC with no clock edge -> state=0 and instret=0 immediately, with no pcWe; with CNT_W=4, 16 retired instructions wrap instret to 0.

Source files
------------

// File: rtl/sr_multicycle_control.sv
// Multi-cycle RV32 subset controller: FETCH/DECODE/EXEC/WB sequencing,
// latched decode, sticky illegal-instruction trap and retired-instruction count.
module sr_multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             runEn,
  output logic             imemReq,
  input  logic             imemAck,
  input  logic [6:0]       cmdOp,
  input  logic [2:0]       cmdF3,
  input  logic [6:0]       cmdF7,
  input  logic             aluZero,
  output logic             irWe,
  output logic             pcWe,
  output logic [1:0]       pcSrc,
  output logic             regWrite,
  output logic             aluSrc,
  output logic [1:0]       wdSrc,
  output logic [2:0]       aluControl,
  output logic             trap,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] S_FETCH  = 3'd0;
  localparam logic [ST_W-1:0] S_DECODE = 3'd1;
  localparam logic [ST_W-1:0] S_EXEC   = 3'd2;
  localparam logic [ST_W-1:0] S_WB     = 3'd3;
  localparam logic [ST_W-1:0] S_TRAP   = 3'd4;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_SRL  = 3'b111;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic [ST_W-1:0]  r_state;
  logic [ST_W-1:0]  w_next;
  logic             r_reg_write;
  logic             r_alu_src;
  logic [1:0]       r_wd_src;
  logic [2:0]       r_alu_ctl;
  logic             r_branch;
  logic             r_jump;
  logic             r_cond_zero;
  logic             r_zero;
  logic             r_trap;
  logic [CNT_W-1:0] r_instret;

  logic       w_valid;
  logic       w_reg_write;
  logic       w_alu_src;
  logic [1:0] w_wd_src;
  logic [2:0] w_alu_ctl;
  logic       w_branch;
  logic       w_jump;
  logic       w_cond_zero;

  // Instruction decode of the IR fields; w_valid low means illegal.
  always_comb begin
    w_valid     = 1'b0;
    w_reg_write = 1'b0;
    w_alu_src   = 1'b0;
    w_wd_src    = 2'b00;
    w_alu_ctl   = ALU_ADD;
    w_branch    = 1'b0;
    w_jump      = 1'b0;
    w_cond_zero = 1'b0;
    case (cmdOp)
      OP_R: begin
        if (cmdF7 == 7'b0000000) begin
          case (cmdF3)
            3'b000:  begin w_valid = 1'b1; w_alu_ctl = ALU_ADD;  end
            3'b110:  begin w_valid = 1'b1; w_alu_ctl = ALU_OR;   end
            3'b101:  begin w_valid = 1'b1; w_alu_ctl = ALU_SRL;  end
            3'b011:  begin w_valid = 1'b1; w_alu_ctl = ALU_SLTU; end
            default: w_valid = 1'b0;
          endcase
        end else if (cmdF7 == 7'b0100000 && cmdF3 == 3'b000) begin
          w_valid   = 1'b1;
          w_alu_ctl = ALU_SUB;
        end
        w_reg_write = w_valid;
      end
      OP_I: begin
        if (cmdF3 == 3'b000) begin
          w_valid     = 1'b1;
          w_reg_write = 1'b1;
          w_alu_src   = 1'b1;
          w_alu_ctl   = ALU_ADD;
        end
      end
      OP_LUI: begin
        w_valid     = 1'b1;
        w_reg_write = 1'b1;
        w_wd_src    = 2'b01;
      end
      OP_BR: begin
        if (cmdF3 == 3'b000 || cmdF3 == 3'b001) begin
          w_valid     = 1'b1;
          w_branch    = 1'b1;
          w_cond_zero = (cmdF3 == 3'b000);
          w_alu_ctl   = ALU_SUB;
        end
      end
      OP_JAL: begin
        w_valid     = 1'b1;
        w_reg_write = 1'b1;
        w_jump      = 1'b1;
        w_wd_src    = 2'b10;
      end
      default: w_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Control register, branch flag, trap flag and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_write <= 1'b0;
      r_alu_src   <= 1'b0;
      r_wd_src    <= 2'b00;
      r_alu_ctl   <= ALU_ADD;
      r_branch    <= 1'b0;
      r_jump      <= 1'b0;
      r_cond_zero <= 1'b0;
      r_zero      <= 1'b0;
      r_trap      <= 1'b0;
      r_instret   <= '0;
    end else begin
      if (r_state == S_DECODE) begin
        r_reg_write <= w_reg_write;
        r_alu_src   <= w_alu_src;
        r_wd_src    <= w_wd_src;
        r_alu_ctl   <= w_alu_ctl;
        r_branch    <= w_branch;
        r_jump      <= w_jump;
        r_cond_zero <= w_cond_zero;
        if (!w_valid) r_trap <= 1'b1;
      end
      if (r_state == S_EXEC) r_zero <= aluZero;
      if (r_state == S_WB)   r_instret <= r_instret + CNT_W'(1);
    end
  end

  // Next state and per-state control outputs.
  always_comb begin
    w_next     = r_state;
    imemReq    = 1'b0;
    irWe       = 1'b0;
    pcWe       = 1'b0;
    pcSrc      = 2'b00;
    regWrite   = 1'b0;
    aluSrc     = 1'b0;
    wdSrc      = 2'b00;
    aluControl = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        imemReq = runEn;
        if (runEn && imemAck) begin
          irWe   = 1'b1;
          w_next = S_DECODE;
        end
      end
      S_DECODE: w_next = w_valid ? S_EXEC : S_TRAP;
      S_EXEC: begin
        aluSrc     = r_alu_src;
        aluControl = r_alu_ctl;
        w_next     = S_WB;
      end
      S_WB: begin
        pcWe       = 1'b1;
        regWrite   = r_reg_write;
        wdSrc      = r_wd_src;
        aluSrc     = r_alu_src;
        aluControl = r_alu_ctl;
        pcSrc      = {r_jump, r_branch & (r_zero == r_cond_zero)};
        w_next     = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end

  assign trap    = r_trap;
  assign state   = r_state;
  assign instret = r_instret;

endmodule

// File: tb/tb_sr_multicycle_control.sv
// Directed self-checking bench for sr_multicycle_control; a second CNT_W=4
// instance shares all inputs to observe counter wrap.
module tb_sr_multicycle_control;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_SRL  = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        runEn;
  logic        imemAck;
  logic [6:0]  cmdOp;
  logic [2:0]  cmdF3;
  logic [6:0]  cmdF7;
  logic        aluZero;

  logic        imemReq, irWe, pcWe, regWrite, aluSrc, trap;
  logic [1:0]  pcSrc, wdSrc;
  logic [2:0]  aluControl, state;
  logic [31:0] instret;

  logic        m4_imemReq, m4_irWe, m4_pcWe, m4_regWrite, m4_aluSrc, m4_trap;
  logic [1:0]  m4_pcSrc, m4_wdSrc;
  logic [2:0]  m4_aluControl, m4_state;
  logic [3:0]  m4_instret;

  int total = 0;
  int bad   = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  sr_multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .runEn(runEn), .imemReq(imemReq), .imemAck(imemAck),
    .cmdOp(cmdOp), .cmdF3(cmdF3), .cmdF7(cmdF7), .aluZero(aluZero),
    .irWe(irWe), .pcWe(pcWe), .pcSrc(pcSrc), .regWrite(regWrite), .aluSrc(aluSrc),
    .wdSrc(wdSrc), .aluControl(aluControl), .trap(trap), .state(state), .instret(instret)
  );

  sr_multicycle_control #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .runEn(runEn), .imemReq(m4_imemReq), .imemAck(imemAck),
    .cmdOp(cmdOp), .cmdF3(cmdF3), .cmdF7(cmdF7), .aluZero(aluZero),
    .irWe(m4_irWe), .pcWe(m4_pcWe), .pcSrc(m4_pcSrc), .regWrite(m4_regWrite),
    .aluSrc(m4_aluSrc), .wdSrc(m4_wdSrc), .aluControl(m4_aluControl), .trap(m4_trap),
    .state(m4_state), .instret(m4_instret)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One instruction from FETCH (ack this cycle) through WB and back to FETCH.
  task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic z, input logic drop,
                           input logic erw, input logic eas, input logic [1:0] ewd,
                           input logic [2:0] ealu, input logic [1:0] epc);
    cmdOp = op; cmdF3 = f3; cmdF7 = f7;
    runEn = 1'b1; imemAck = 1'b1;
    #1;
    chk({tag, ".f_state"}, 64'(state), 64'd0);
    chk({tag, ".f_req"}, 64'(imemReq), 64'd1);
    chk({tag, ".f_irwe"}, 64'(irWe), 64'd1);
    cyc();
    imemAck = 1'b0;
    if (drop) runEn = 1'b0;
    #1;
    chk({tag, ".d_state"}, 64'(state), 64'd1);
    chk({tag, ".d_irwe"}, 64'(irWe), 64'd0);
    chk({tag, ".d_req"}, 64'(imemReq), 64'd0);
    chk({tag, ".d_pcwe"}, 64'(pcWe), 64'd0);
    cyc();
    aluZero = z;
    #1;
    chk({tag, ".e_state"}, 64'(state), 64'd2);
    chk({tag, ".e_alusrc"}, 64'(aluSrc), 64'(eas));
    chk({tag, ".e_aluctl"}, 64'(aluControl), 64'(ealu));
    chk({tag, ".e_rw"}, 64'(regWrite), 64'd0);
    chk({tag, ".e_pcwe"}, 64'(pcWe), 64'd0);
    cyc();
    aluZero = 1'b0;
    #1;
    chk({tag, ".w_state"}, 64'(state), 64'd3);
    chk({tag, ".w_pcwe"}, 64'(pcWe), 64'd1);
    chk({tag, ".w_rw"}, 64'(regWrite), 64'(erw));
    chk({tag, ".w_alusrc"}, 64'(aluSrc), 64'(eas));
    chk({tag, ".w_wdsrc"}, 64'(wdSrc), 64'(ewd));
    chk({tag, ".w_aluctl"}, 64'(aluControl), 64'(ealu));
    chk({tag, ".w_pcsrc"}, 64'(pcSrc), 64'(epc));
    chk({tag, ".w_instret"}, 64'(instret), 64'(exp_ret));
    exp_ret++;
    cyc();
    chk({tag, ".n_state"}, 64'(state), 64'd0);
    chk({tag, ".n_pcwe"}, 64'(pcWe), 64'd0);
    chk({tag, ".n_instret"}, 64'(instret), 64'(exp_ret));
    chk({tag, ".n_instret4"}, 64'(m4_instret), 64'(exp_ret % 16));
    chk({tag, ".n_req"}, 64'(imemReq), 64'(runEn));
  endtask

  initial begin
    rst_n = 1'b1; runEn = 1'b0; imemAck = 1'b0; aluZero = 1'b0;
    cmdOp = 7'd0; cmdF3 = 3'd0; cmdF7 = 7'd0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst.state", 64'(state), 64'd0);
    chk("rst.instret", 64'(instret), 64'd0);
    chk("rst.trap", 64'(trap), 64'd0);
    chk("rst.req", 64'(imemReq), 64'd0);
    chk("rst.pcwe", 64'(pcWe), 64'd0);
    chk("rst.aluctl", 64'(aluControl), 64'(ALU_ADD));
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    chk("idle.req_off", 64'(imemReq), 64'd0);
    runEn = 1'b1;
    #1;
    chk("c1.req", 64'(imemReq), 64'd1);
    chk("c1.irwe", 64'(irWe), 64'd0);
    cyc();

    run_instr("addi", 7'b0010011, 3'b000, 7'h00, 1'b0, 1'b0, 1, 1, 2'b00, ALU_ADD, 2'b00);
    run_instr("beq_z1", 7'b1100011, 3'b000, 7'h00, 1'b1, 1'b0, 0, 0, 2'b00, ALU_SUB, 2'b01);
    run_instr("bne_z1", 7'b1100011, 3'b001, 7'h00, 1'b1, 1'b0, 0, 0, 2'b00, ALU_SUB, 2'b00);
    run_instr("bne_z0", 7'b1100011, 3'b001, 7'h00, 1'b0, 1'b0, 0, 0, 2'b00, ALU_SUB, 2'b01);
    run_instr("jal", 7'b1101111, 3'b000, 7'h00, 1'b0, 1'b0, 1, 0, 2'b10, ALU_ADD, 2'b10);
    run_instr("add", 7'b0110011, 3'b000, 7'h00, 1'b0, 1'b0, 1, 0, 2'b00, ALU_ADD, 2'b00);
    run_instr("sub", 7'b0110011, 3'b000, 7'h20, 1'b0, 1'b0, 1, 0, 2'b00, ALU_SUB, 2'b00);
    run_instr("or", 7'b0110011, 3'b110, 7'h00, 1'b0, 1'b0, 1, 0, 2'b00, ALU_OR, 2'b00);
    run_instr("srl", 7'b0110011, 3'b101, 7'h00, 1'b0, 1'b0, 1, 0, 2'b00, ALU_SRL, 2'b00);
    run_instr("sltu", 7'b0110011, 3'b011, 7'h00, 1'b1, 1'b0, 1, 0, 2'b00, ALU_SLTU, 2'b00);
    run_instr("lui", 7'b0110111, 3'b010, 7'h55, 1'b0, 1'b0, 1, 0, 2'b01, ALU_ADD, 2'b00);
    run_instr("drop", 7'b0010011, 3'b000, 7'h00, 1'b0, 1'b1, 1, 1, 2'b00, ALU_ADD, 2'b00);

    // Acknowledge withheld, then offered while runEn is low.
    runEn = 1'b1; imemAck = 1'b0;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("wait.state", 64'(state), 64'd0);
      chk("wait.req", 64'(imemReq), 64'd1);
      cyc();
    end
    runEn = 1'b0; imemAck = 1'b1;
    #1;
    chk("noen.req", 64'(imemReq), 64'd0);
    chk("noen.irwe", 64'(irWe), 64'd0);
    cyc();
    chk("noen.state", 64'(state), 64'd0);
    imemAck = 1'b0;

    for (int i = 0; i < 4; i++)
      run_instr("fill", 7'b0010011, 3'b000, 7'h00, 1'b0, 1'b0, 1, 1, 2'b00, ALU_ADD, 2'b00);
    chk("wrap.count", 64'(instret), 64'd16);
    chk("wrap.cnt4", 64'(m4_instret), 64'd0);

    // Asynchronous reset in the middle of EXEC.
    cmdOp = 7'b0010011; cmdF3 = 3'b000; runEn = 1'b1; imemAck = 1'b1;
    cyc();
    imemAck = 1'b0;
    cyc();
    chk("mid.exec", 64'(state), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.state", 64'(state), 64'd0);
    chk("mid.instret", 64'(instret), 64'd0);
    chk("mid.pcwe", 64'(pcWe), 64'd0);
    chk("mid.rw", 64'(regWrite), 64'd0);
    exp_ret = 0;
    runEn = 1'b0;
    cyc();
    cyc();
    chk("mid.hold_pcwe", 64'(pcWe), 64'd0);
    rst_n = 1'b1;
    cyc();
    chk("post.req_off", 64'(imemReq), 64'd0);
    runEn = 1'b1;
    #1;
    chk("post.req_on", 64'(imemReq), 64'd1);
    cyc();
    run_instr("post", 7'b0010011, 3'b000, 7'h00, 1'b0, 1'b0, 1, 1, 2'b00, ALU_ADD, 2'b00);

    // Illegal opcode: terminal trap.
    cmdOp = 7'b0000000; cmdF3 = 3'b000; cmdF7 = 7'h00;
    runEn = 1'b1; imemAck = 1'b1;
    cyc();
    chk("ill.decode", 64'(state), 64'd1);
    cyc();
    chk("ill.state", 64'(state), 64'd4);
    chk("ill.trap", 64'(trap), 64'd1);
    for (int i = 0; i < 20; i++) begin
      chk("trap.req", 64'(imemReq), 64'd0);
      chk("trap.state", 64'(state), 64'd4);
      chk("trap.pcwe", 64'(pcWe), 64'd0);
      chk("trap.irwe", 64'(irWe), 64'd0);
      cyc();
    end
    chk("trap.instret", 64'(instret), 64'(exp_ret));
    chk("trap.sticky", 64'(trap), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
